// File: rtl/swap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swap_pkg
// Description : Shared step encodings for swap_fsm / swap_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package swap_pkg;

    localparam logic [1:0] SEL_IDLE = 2'd0;
    localparam logic [1:0] SEL_TA   = 2'd1;
    localparam logic [1:0] SEL_AB   = 2'd2;
    localparam logic [1:0] SEL_BT   = 2'd3;

    // Expected-step encoding matches the sel value of that step.
    typedef enum logic [1:0] {
        STEP_TA = 2'd1,
        STEP_AB = 2'd2,
        STEP_BT = 2'd3
    } step_e;

    function automatic step_e next_step(input step_e cur);
        case (cur)
            STEP_TA: next_step = STEP_AB;
            STEP_AB: next_step = STEP_BT;
            default: next_step = STEP_TA;
        endcase
    endfunction

endpackage : swap_pkg
`default_nettype wire

// File: rtl/swap_seq_check.sv
`default_nettype none
// ============================================================================
// Module      : swap_seq_check
// Description : Tracks the expected swap step and classifies each w/sel pair.
// Revision    : 1.0 - initial release
// ============================================================================
module swap_seq_check
    import swap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_w,
    input  logic [1:0] i_sel,
    output logic       o_step_ok,
    output logic       o_step_err,
    output logic       o_last_step,
    output logic       o_idle,
    output logic       o_busy
);

    step_e exp_q;
    step_e exp_d;

    always_comb begin
        o_step_ok   = i_w && (i_sel == exp_q);
        o_idle      = !i_w && (i_sel == SEL_IDLE) && (exp_q == STEP_TA);
        o_step_err  = !o_step_ok && !o_idle;
        o_last_step = o_step_ok && (exp_q == STEP_BT);
        o_busy      = (exp_q != STEP_TA);

        exp_d = exp_q;
        if (o_step_ok) begin
            exp_d = next_step(exp_q);
        end else if (o_step_err) begin
            // Any protocol violation aborts the swap in progress.
            exp_d = STEP_TA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q <= STEP_TA;
        end else begin
            exp_q <= exp_d;
        end
    end

endmodule : swap_seq_check
`default_nettype wire

// File: rtl/swap_datapath.sv
`default_nettype none
// ============================================================================
// Module      : swap_datapath
// Description : A/B/T register datapath executing the 3-step swap from
//               swap_fsm, with host load, done pulse, counter and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module swap_datapath
    import swap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w,
    input  logic [1:0]        sel,
    input  logic              load_a,
    input  logic              load_b,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_count,
    output logic              load_err,
    output logic              seq_err
);

    logic w_step_ok;
    logic w_step_err;
    logic w_last_step;
    logic w_idle;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              load_err_q, load_err_d;
    logic              seq_err_q, seq_err_d;

    swap_seq_check u_seq_check (
        .clk         (clk),
        .reset       (reset),
        .i_w         (w),
        .i_sel       (sel),
        .o_step_ok   (w_step_ok),
        .o_step_err  (w_step_err),
        .o_last_step (w_last_step),
        .o_idle      (w_idle),
        .o_busy      (busy)
    );

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        t_d        = t_q;
        count_d    = count_q;
        done_d     = 1'b0;
        load_err_d = load_err_q;
        seq_err_d  = seq_err_q;

        if (w_step_ok) begin
            case (sel)
                SEL_TA:  t_d = a_q;
                SEL_AB:  a_d = b_q;
                SEL_BT:  b_d = t_q;
                default: ;
            endcase
        end else if (w_idle) begin
            if (load_a) a_d = data_in;
            if (load_b) b_d = data_in;
        end

        if (w_last_step) begin
            done_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
        end

        // A fresh error in the same cycle as clr_err must win.
        if (clr_err) begin
            load_err_d = 1'b0;
            seq_err_d  = 1'b0;
        end
        if (w_step_err) seq_err_d = 1'b1;
        if (w && (load_a || load_b)) load_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            t_q        <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            t_q        <= t_d;
            count_q    <= count_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign done       = done_q;
    assign swap_count = count_q;
    assign load_err   = load_err_q;
    assign seq_err    = seq_err_q;

endmodule : swap_datapath
`default_nettype wire

// File: tb/tb_swap_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_swap_datapath
// Description : Randomized + directed self-checking bench for swap_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_datapath;

    logic       clk;
    logic       reset;
    logic       w;
    logic [1:0] sel;
    logic       load_a;
    logic       load_b;
    logic [7:0] data_in;
    logic       clr_err;

    logic [7:0] a_out, b_out;
    logic       busy, done, load_err, seq_err;
    logic [7:0] swap_count;

    logic [7:0] a2_out, b2_out;
    logic       busy2, done2, load_err2, seq_err2;
    logic [1:0] swap_count2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: swap progress is "number of valid steps taken so far".
    int m_a, m_b, m_t, m_prog, m_cnt;
    bit m_done, m_le, m_se;
    int done2_pulses;

    swap_datapath #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .w(w), .sel(sel),
        .load_a(load_a), .load_b(load_b), .data_in(data_in), .clr_err(clr_err),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
        .swap_count(swap_count), .load_err(load_err), .seq_err(seq_err)
    );

    swap_datapath #(.DATA_W(8), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .w(w), .sel(sel),
        .load_a(load_a), .load_b(load_b), .data_in(data_in), .clr_err(clr_err),
        .a_out(a2_out), .b_out(b2_out), .busy(busy2), .done(done2),
        .swap_count(swap_count2), .load_err(load_err2), .seq_err(seq_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_t = 0; m_prog = 0; m_cnt = 0;
        m_done = 0; m_le = 0; m_se = 0;
    endtask

    task automatic model_step();
        bit valid, idle, new_se, new_le;
        valid  = w && (int'(sel) == m_prog + 1);
        idle   = !w && sel == 2'd0 && m_prog == 0;
        new_se = !valid && !idle;
        new_le = w && (load_a || load_b);
        m_done = 0;
        if (valid) begin
            if (sel == 2'd1) m_t = m_a;
            if (sel == 2'd2) m_a = m_b;
            if (sel == 2'd3) begin
                m_b = m_t;
                m_cnt++;
                m_done = 1;
            end
            m_prog = (m_prog + 1) % 3;
        end else if (idle) begin
            if (load_a) m_a = data_in;
            if (load_b) m_b = data_in;
        end else begin
            m_prog = 0;
        end
        if (clr_err) begin m_le = 0; m_se = 0; end
        if (new_se) m_se = 1;
        if (new_le) m_le = 1;
    endtask

    task automatic check_all();
        check("a_out",       a_out,       m_a);
        check("b_out",       b_out,       m_b);
        check("busy",        busy,        m_prog != 0);
        check("done",        done,        m_done);
        check("swap_count",  swap_count,  m_cnt % 256);
        check("load_err",    load_err,    m_le);
        check("seq_err",     seq_err,     m_se);
        check("done_w2",     done2,       m_done);
        check("swap_count2", swap_count2, m_cnt % 4);
    endtask

    task automatic cycle(input bit iw, input int isel, input bit la, input bit lb,
                         input int d, input bit ce);
        @(negedge clk);
        w = iw; sel = isel[1:0]; load_a = la; load_b = lb; data_in = d[7:0]; clr_err = ce;
        @(posedge clk);
        model_step();
        #1;
        if (done2) done2_pulses++;
        check_all();
    endtask

    task automatic swap_once();
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 2, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0, 0);
    endtask

    initial begin
        bit rw, rla, rlb, rce;
        int rsel, r;
        reset = 1'b1; w = 0; sel = 0; load_a = 0; load_b = 0; data_in = 0; clr_err = 0;
        model_reset();
        #12;
        check("rst_a", a_out, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", swap_count, 0);
        check("rst_err", {load_err, seq_err, done}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic swap
        cycle(0, 0, 1, 0, 8'h3C, 0);
        cycle(0, 0, 0, 1, 8'hA5, 0);
        swap_once();
        check("t1_a", a_out, 8'hA5);
        check("t1_b", b_out, 8'h3C);
        check("t1_done", done, 1);
        check("t1_cnt", swap_count, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("t1_done_off", done, 0);

        // Back-to-back swaps
        swap_once();
        swap_once();
        check("t2_a", a_out, 8'hA5);
        check("t2_b", b_out, 8'h3C);
        check("t2_cnt", swap_count, 3);
        cycle(0, 0, 0, 0, 0, 0);

        // Load during a step is ignored and flagged
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 2, 1, 0, 8'hFF, 0);
        cycle(1, 3, 0, 0, 0, 0);
        check("t3_le", load_err, 1);
        check("t3_a", a_out, 8'h3C);
        cycle(0, 0, 0, 0, 0, 1);
        check("t3_clr", load_err, 0);

        // Skipped step aborts the swap
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0, 0);
        check("t4_se", seq_err, 1);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_b", b_out, 8'hA5);
        cycle(0, 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of step 2
        cycle(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        w = 1; sel = 2'd2;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("t5_a", a_out, 0);
        check("t5_b", b_out, 0);
        check("t5_busy", busy, 0);
        check("t5_cnt", swap_count, 0);
        @(negedge clk);
        w = 0; sel = 0;
        reset = 1'b0;

        // Narrow counter wraps
        done2_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            swap_once();
            cycle(0, 0, 0, 0, 0, 0);
        end
        check("t6_cnt2", swap_count2, 1);
        check("t6_pulses", done2_pulses, 5);

        // Randomized traffic, mostly legal sequences
        for (int i = 0; i < 400; i++) begin
            r   = $urandom_range(0, 9);
            rce = ($urandom_range(0, 7) == 0);
            rla = 0; rlb = 0;
            if (r < 7) begin
                if (m_prog == 0 && $urandom_range(0, 2) == 0) begin
                    rw = 0; rsel = 0;
                    rla = $urandom_range(0, 1); rlb = $urandom_range(0, 1);
                end else begin
                    rw = 1; rsel = m_prog + 1;
                    rla = (r == 6);
                end
            end else begin
                rw = $urandom_range(0, 1); rsel = $urandom_range(0, 3);
                rla = $urandom_range(0, 1); rlb = $urandom_range(0, 1);
            end
            cycle(rw, rsel, rla, rlb, $urandom_range(0, 255), rce);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_swap_datapath
`default_nettype wire
